exp_diff_seq: RTL and testbench



---
 rtl/exp_diff_seq_pkg.sv | 14 +
 rtl/fsub_cell.sv | 21 ++
 rtl/exp_diff_seq.sv | 112 +++++++++++
 tb/tb_exp_diff_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/exp_diff_seq_pkg.sv
// Shared fp-adder definitions: exponent width default and the
// exponent-difference sequencer state encoding.
package exp_diff_seq_pkg;

    localparam int unsigned EXP_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StSub,
        StNeg,
        StDone
    } ed_state_e;

endpackage

// File: rtl/fsub_cell.sv
// Combinational 1-bit full subtractor (x - y - bin) built from two
// half-subtractor stages.
module fsub_cell (
    input  logic x_i,
    input  logic y_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    logic d1;
    logic b1;
    logic b2;

    assign d1     = x_i ^ y_i;
    assign b1     = ~x_i & y_i;
    assign d_o    = d1 ^ bin_i;
    assign b2     = ~d1 & bin_i;
    assign bout_o = b1 | b2;

endmodule

// File: rtl/exp_diff_seq.sv
// Bit-serial |ea - eb| sequencer: one subtract pass, then an optional
// two's-complement negation pass through the same 1-bit cell.
module exp_diff_seq
    import exp_diff_seq_pkg::*;
#(
    parameter int unsigned W = EXP_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [W-1:0] ea_i,
    input  logic [W-1:0] eb_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] diff_o,
    output logic         a_lt_b_o
);

    localparam int unsigned CntW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(W - 1);

    ed_state_e     state_q, state_d;
    logic [W-1:0]  sa_q, sa_d;
    logic [W-1:0]  sb_q, sb_d;
    logic [W-1:0]  r_q, r_d;
    logic          bq_q, bq_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic          lt_q, lt_d;

    logic cell_d;
    logic cell_bout;

    fsub_cell u_fsub_cell (
        .x_i   (sa_q[0]),
        .y_i   (sb_q[0]),
        .bin_i (bq_q),
        .d_o   (cell_d),
        .bout_o(cell_bout)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            r_q     <= '0;
            bq_q    <= 1'b0;
            cnt_q   <= '0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            r_q     <= r_d;
            bq_q    <= bq_d;
            cnt_q   <= cnt_d;
            lt_q    <= lt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        r_d     = r_q;
        bq_d    = bq_q;
        cnt_d   = cnt_q;
        lt_d    = lt_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    sa_d    = ea_i;
                    sb_d    = eb_i;
                    bq_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StSub;
                end
            end
            StSub, StNeg: begin
                r_d   = {cell_d, r_q[W-1:1]};
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                bq_d  = cell_bout;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntMax) begin
                    if (state_q == StSub && cell_bout) begin
                        // Negative result: rerun the cell as 0 - r.
                        lt_d    = 1'b1;
                        sa_d    = '0;
                        sb_d    = {cell_d, r_q[W-1:1]};
                        bq_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = StNeg;
                    end else begin
                        if (state_q == StSub) begin
                            lt_d = 1'b0;
                        end
                        state_d = StDone;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign busy_o   = (state_q != StIdle);
    assign done_o   = (state_q == StDone);
    assign diff_o   = r_q;
    assign a_lt_b_o = lt_q;

endmodule

// File: tb/tb_exp_diff_seq.sv
// Directed and random checks of the bit-serial exponent-difference sequencer.
module tb_exp_diff_seq;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         a_lt_b;

    int n_vec;
    int n_bad;

    exp_diff_seq #(.W(W)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .ea_i    (ea),
        .eb_i    (eb),
        .busy_o  (busy),
        .done_o  (done),
        .diff_o  (diff),
        .a_lt_b_o(a_lt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One operation with a start pulse; expected results supplied by caller.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_diff, input logic exp_lt);
        int  edges;
        int  busy_cyc;
        bit  seen;
        int  exp_lat;
        exp_lat = exp_lt ? 2 * W + 1 : W + 1;
        @(negedge clk);
        start = 1'b1;
        ea    = a;
        eb    = b;
        @(posedge clk);
        edges = 1;
        #1;
        start = 1'b0;
        ea    = W'($urandom);
        eb    = W'($urandom);
        busy_cyc = 0;
        seen = 1'b0;
        for (int i = 0; i < 4 * W && !seen; i++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done) begin
                seen = 1'b1;
                check_eq({tag, " diff"}, 32'(diff), 32'(exp_diff));
                check_eq({tag, " a_lt_b"}, 32'(a_lt_b), 32'(exp_lt));
                check_eq({tag, " latency"}, 32'(edges), 32'(exp_lat));
                check_eq({tag, " busy cycles"}, 32'(busy_cyc), 32'(exp_lat));
            end else begin
                @(posedge clk);
                edges++;
            end
        end
        check_eq({tag, " done seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        check_eq({tag, " done width"}, 32'(done), 32'd0);
        check_eq({tag, " busy after"}, 32'(busy), 32'd0);
        check_eq({tag, " diff hold"}, 32'(diff), 32'(exp_diff));
    endtask

    initial begin
        int       edges;
        int       ndone;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        ea    = '0;
        eb    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset done", 32'(done), 32'd0);
        check_eq("reset diff", 32'(diff), 32'd0);
        check_eq("reset a_lt_b", 32'(a_lt_b), 32'd0);
        rst_n = 1'b1;

        run_op("130-127", 8'd130, 8'd127, 8'd3, 1'b0);
        run_op("100-120", 8'd100, 8'd120, 8'd20, 1'b1);
        run_op("77-77", 8'd77, 8'd77, 8'd0, 1'b0);
        run_op("255-0", 8'd255, 8'd0, 8'd255, 1'b0);
        run_op("0-255", 8'd0, 8'd255, 8'd255, 1'b1);

        // start held through two operations; operands change after acceptance
        @(negedge clk);
        start = 1'b1;
        ea    = 8'd200;
        eb    = 8'd50;
        @(posedge clk);
        #1;
        ea    = 8'd5;
        eb    = 8'd9;
        edges = 1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    check_eq("held first diff", 32'(diff), 32'd150);
                    check_eq("held first a_lt_b", 32'(a_lt_b), 32'd0);
                    check_eq("held first latency", 32'(edges), 32'd9);
                end else if (ndone == 2) begin
                    check_eq("held second diff", 32'(diff), 32'd4);
                    check_eq("held second a_lt_b", 32'(a_lt_b), 32'd1);
                    check_eq("held second latency", 32'(edges), 32'd27);
                    start = 1'b0;
                end
            end
            @(posedge clk);
            edges++;
        end
        check_eq("held done count", 32'(ndone), 32'd2);

        // reset on the fourth SUB cycle
        @(negedge clk);
        start = 1'b1;
        ea    = 8'd100;
        eb    = 8'd120;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("pre-reset busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("midreset busy", 32'(busy), 32'd0);
        check_eq("midreset done", 32'(done), 32'd0);
        check_eq("midreset diff", 32'(diff), 32'd0);
        check_eq("midreset a_lt_b", 32'(a_lt_b), 32'd0);
        run_op("12-3", 8'd12, 8'd3, 8'd9, 1'b0);

        for (int k = 0; k < 1000; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op("random", ra, rb, (ra >= rb) ? ra - rb : rb - ra, ra < rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
